hpdcache_sram_ecc_scrubber: RTL and testbench
=============================================

HPDCACHE_SRAM_ECC_SCRUBBER -- requirements
Module: hpdcache_sram_ecc_scrubber

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 6, SRAM row address width.
REQ-002 SHALL have parameter DATA_SIZE, default 64, data bits per word (excludes check bits).
REQ-003 SHALL have parameter NDATA, default 1, words per row.
REQ-004 SHALL have parameter DEPTH, default 2**ADDR_SIZE, rows scrubbed; DEPTH <= 2**ADDR_SIZE.
REQ-005 SHALL have port clk_i, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports en_i (input, 1) and period_i (input, 16): scrub enable; idle cycles between rows.
REQ-008 SHALL have ports sram_req_o (output, 1) and sram_gnt_i (input, 1): access request to port arbiter; grant in same cycle.
REQ-009 SHALL have ports sram_we_o (1), sram_addr_o (ADDR_SIZE), sram_wdata_o and sram_wmask_o (NDATA*DATA_SIZE), all outputs.
REQ-010 SHALL have inputs sram_rdata_i (NDATA*DATA_SIZE, corrected data), sram_err_cor_i (NDATA) and sram_err_unc_i (NDATA), valid one cycle after a granted read.
REQ-011 SHALL have inputs fn_wr_i (1) and fn_wr_addr_i (ADDR_SIZE): snoop of functional writes.
REQ-012 SHALL have outputs busy_o (1), cor_evt_o (1) and unc_evt_o (1), the latter two single-cycle pulses.
REQ-013 SHALL have outputs cor_cnt_o (16), unc_cnt_o (16) and unc_addr_o (ADDR_SIZE).

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RD, RESP, WB.
REQ-015 IDLE->WAIT when en_i=1, loading period timer with period_i.
REQ-016 WAIT SHALL decrement timer each cycle; ->RD when timer==0 (period_i=0 means direct WAIT->RD next cycle).
REQ-017 RD SHALL hold sram_req_o=1, sram_we_o=0, sram_addr_o=row pointer until sram_gnt_i=1, then ->RESP.
REQ-018 RESP (one cycle after grant) SHALL sample rdata/err inputs.
REQ-019 In RESP, any err_unc bit set SHALL pulse unc_evt_o, increment unc_cnt_o, capture unc_addr_o=pointer, skip write-back.
REQ-020 In RESP, no err_unc and any err_cor bit set SHALL pulse cor_evt_o, increment cor_cnt_o once per row, ->WB.
REQ-021 WB SHALL request write with sram_we_o=1, wdata=captured corrected data, wmask word i all-ones iff err_cor[i], else zero.
REQ-022 Functional write to pointer address (fn_wr_i=1, fn_wr_addr_i==pointer) observed from RD grant cycle through WB grant SHALL cancel write-back; row is done.
REQ-023 Write-back SHALL complete on the cycle sram_gnt_i=1 in WB.
REQ-024 Row done: pointer increments; wraps DEPTH-1->0; en_i=1 ->WAIT (timer reload), else ->IDLE.
REQ-025 en_i deassertion mid-row SHALL not abort; current row completes.
REQ-026 sram_req_o SHALL be 0 outside RD/WB; all SRAM outputs zero when sram_req_o=0.
REQ-027 Counters SHALL saturate at 16'hFFFF.
REQ-028 busy_o SHALL be 1 in RD, RESP, WB.

Reset
REQ-029 rst_i=1 SHALL force IDLE, pointer=0, timer=0, counters=0, unc_addr_o=0, all outputs 0 next cycle.
REQ-030 rst_i mid-row SHALL discard captured data; no write-back issued after reset.

Configuration
REQ-031 Macro HPDCACHE_SCRUB_ERR_LOG_EN defined: cor_cnt_o, unc_cnt_o, unc_addr_o implemented per REQ-019/020/027.
REQ-032 Macro undefined: those outputs tied 0, no counter/log flops; event pulses and write-back unchanged.

Verification
REQ-033 DEPTH=4, period_i=0, grant always 1, no errors -> reads rows 0,1,2,3,0 on successive 2-cycle slots; no writes.
REQ-034 Row 2 err_cor=1 word 0, data 64'hA5 -> cor_evt_o pulse, write addr 2, wdata 64'hA5, wmask word0 all-ones, cor_cnt_o=1.
REQ-035 Row 1 err_unc=1 -> unc_evt_o pulse, unc_cnt_o=1, unc_addr_o=1, no write issued.
REQ-036 err_cor on row 3, fn_wr_i with fn_wr_addr_i=3 during WB with sram_gnt_i=0 -> write-back cancelled, pointer=0.
REQ-037 rst_i asserted in RESP with err_cor -> no write, pointer=0, counters 0; period_i=5 then gives 5 WAIT cycles between reads.
REQ-038 Macro undefined, err_unc row 1 -> unc_evt_o pulses, unc_cnt_o and unc_addr_o stay 0.

Source files
------------

// File: rtl/hpdcache_sram_ecc_scrubber.sv
// Background ECC scrubber: walks SRAM rows, re-writes corrected words, flags uncorrectable rows.
// Error counters/log exist only with HPDCACHE_SCRUB_ERR_LOG_EN; SRAM accesses wait on sram_gnt_i.
module hpdcache_sram_ecc_scrubber #(
    parameter int unsigned ADDR_SIZE = 6,
    parameter int unsigned DATA_SIZE = 64,
    parameter int unsigned NDATA     = 1,
    parameter int unsigned DEPTH     = 2**ADDR_SIZE
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic [15:0]                  period_i,
    output logic                         sram_req_o,
    input  logic                         sram_gnt_i,
    output logic                         sram_we_o,
    output logic [ADDR_SIZE-1:0]         sram_addr_o,
    output logic [NDATA*DATA_SIZE-1:0]   sram_wdata_o,
    output logic [NDATA*DATA_SIZE-1:0]   sram_wmask_o,
    input  logic [NDATA*DATA_SIZE-1:0]   sram_rdata_i,
    input  logic [NDATA-1:0]             sram_err_cor_i,
    input  logic [NDATA-1:0]             sram_err_unc_i,
    input  logic                         fn_wr_i,
    input  logic [ADDR_SIZE-1:0]         fn_wr_addr_i,
    output logic                         busy_o,
    output logic                         cor_evt_o,
    output logic                         unc_evt_o,
    output logic [15:0]                  cor_cnt_o,
    output logic [15:0]                  unc_cnt_o,
    output logic [ADDR_SIZE-1:0]         unc_addr_o
);
    localparam int unsigned W = NDATA * DATA_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_ROW = ADDR_SIZE'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WAIT, RD, RESP, WB} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
    logic [15:0]            timer_q, timer_d;
    logic                   cancel_q, cancel_d;
    logic [W-1:0]           wdata_q, wdata_d;
    logic [W-1:0]           wmask_q, wmask_d;
    logic                   cor_evt_q, cor_evt_d;
    logic                   unc_evt_q, unc_evt_d;
    logic                   row_done;
    logic                   fn_hit;

    assign fn_hit = fn_wr_i && (fn_wr_addr_i == ptr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            timer_q   <= '0;
            cancel_q  <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            cor_evt_q <= 1'b0;
            unc_evt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            cancel_q  <= cancel_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            cor_evt_q <= cor_evt_d;
            unc_evt_q <= unc_evt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        cancel_d     = cancel_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        cor_evt_d    = 1'b0;
        unc_evt_d    = 1'b0;
        row_done     = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        unique case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = WAIT;
                    timer_d = period_i;
                end
            end
            WAIT: begin
                // Leaving at timer<=1 yields exactly period_i idle cycles between rows
                timer_d = (timer_q == 16'd0) ? 16'd0 : timer_q - 16'd1;
                if (timer_q <= 16'd1) state_d = RD;
            end
            RD: begin
                sram_req_o  = 1'b1;
                sram_addr_o = ptr_q;
                if (sram_gnt_i) begin
                    state_d  = RESP;
                    cancel_d = fn_hit;
                end
            end
            RESP: begin
                wdata_d = sram_rdata_i;
                for (int i = 0; i < NDATA; i++)
                    wmask_d[i*DATA_SIZE +: DATA_SIZE] = {DATA_SIZE{sram_err_cor_i[i]}};
                if (|sram_err_unc_i) begin
                    unc_evt_d = 1'b1;
                    row_done  = 1'b1;
                end else if (|sram_err_cor_i) begin
                    cor_evt_d = 1'b1;
                    if (cancel_q || fn_hit) row_done = 1'b1;
                    else                    state_d  = WB;
                end else begin
                    row_done = 1'b1;
                end
            end
            WB: begin
                // A functional write to this row supersedes the scrubbed data
                if (fn_hit) begin
                    row_done = 1'b1;
                end else begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = ptr_q;
                    sram_wdata_o = wdata_q;
                    sram_wmask_o = wmask_q;
                    if (sram_gnt_i) row_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (row_done) begin
            ptr_d    = (ptr_q == LAST_ROW) ? '0 : ptr_q + 1'b1;
            cancel_d = 1'b0;
            if (!en_i) begin
                state_d = IDLE;
            end else if (period_i == 16'd0) begin
                state_d = RD;
            end else begin
                state_d = WAIT;
                timer_d = period_i;
            end
        end
    end

    assign busy_o    = (state_q == RD) || (state_q == RESP) || (state_q == WB);
    assign cor_evt_o = cor_evt_q;
    assign unc_evt_o = unc_evt_q;

`ifdef HPDCACHE_SCRUB_ERR_LOG_EN
    logic [15:0]          cor_cnt_q, unc_cnt_q;
    logic [ADDR_SIZE-1:0] unc_addr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cor_cnt_q  <= '0;
            unc_cnt_q  <= '0;
            unc_addr_q <= '0;
        end else if (state_q == RESP) begin
            if (|sram_err_unc_i) begin
                if (unc_cnt_q != 16'hFFFF) unc_cnt_q <= unc_cnt_q + 16'd1;
                unc_addr_q <= ptr_q;
            end else if (|sram_err_cor_i) begin
                if (cor_cnt_q != 16'hFFFF) cor_cnt_q <= cor_cnt_q + 16'd1;
            end
        end
    end

    assign cor_cnt_o  = cor_cnt_q;
    assign unc_cnt_o  = unc_cnt_q;
    assign unc_addr_o = unc_addr_q;
`else
    assign cor_cnt_o  = '0;
    assign unc_cnt_o  = '0;
    assign unc_addr_o = '0;
`endif

endmodule

// File: tb/tb_hpdcache_sram_ecc_scrubber.sv
// Bench for the ECC scrubber: SRAM responder plus a row-level reference model of expected reads/writes/events.
`timescale 1ns/1ps
module tb_hpdcache_sram_ecc_scrubber;
    localparam int AW = 3, DW = 64, ND = 2, DEPTH = 4, W = ND * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i = 1'b1, en_i = 1'b0;
    logic [15:0]    period_i = '0;
    logic           sram_req_o, sram_gnt_i = 1'b0, sram_we_o;
    logic [AW-1:0]  sram_addr_o;
    logic [W-1:0]   sram_wdata_o, sram_wmask_o, sram_rdata_i = '0;
    logic [ND-1:0]  sram_err_cor_i = '0, sram_err_unc_i = '0;
    logic           fn_wr_i = 1'b0;
    logic [AW-1:0]  fn_wr_addr_i = '0;
    logic           busy_o, cor_evt_o, unc_evt_o;
    logic [15:0]    cor_cnt_o, unc_cnt_o;
    logic [AW-1:0]  unc_addr_o;

    hpdcache_sram_ecc_scrubber #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .NDATA(ND), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst_i), .en_i(en_i), .period_i(period_i),
        .sram_req_o(sram_req_o), .sram_gnt_i(sram_gnt_i), .sram_we_o(sram_we_o),
        .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_wmask_o(sram_wmask_o),
        .sram_rdata_i(sram_rdata_i), .sram_err_cor_i(sram_err_cor_i), .sram_err_unc_i(sram_err_unc_i),
        .fn_wr_i(fn_wr_i), .fn_wr_addr_i(fn_wr_addr_i), .busy_o(busy_o),
        .cor_evt_o(cor_evt_o), .unc_evt_o(unc_evt_o), .cor_cnt_o(cor_cnt_o),
        .unc_cnt_o(unc_cnt_o), .unc_addr_o(unc_addr_o)
    );

`ifdef HPDCACHE_SCRUB_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    int checks = 0, errors = 0, cyc = 0;

    // Per-row error/data table, or random errors/data when enabled
    logic [ND-1:0] tab_cor [DEPTH];
    logic [ND-1:0] tab_unc [DEPTH];
    logic [W-1:0]  tab_data[DEPTH];
    bit rand_mode = 0;
    int gnt_pct = 100;
    bit cancel_wb = 0, cancel_seen = 0, req_at_cancel = 0;
    bit rst_in_resp = 0;
    bit pending = 0;
    logic [AW-1:0] pend_addr;

    int            rd_addr_q[$], rd_cyc_q[$], wr_addr_q[$];
    logic [W-1:0]  wr_data_q[$], wr_mask_q[$];
    int            rs_addr_q[$];
    logic [W-1:0]  rs_data_q[$];
    logic [ND-1:0] rs_cor_q[$], rs_unc_q[$];
    int cor_pulses = 0, unc_pulses = 0;

    function automatic logic [W-1:0] mask_of(input logic [ND-1:0] c);
        logic [W-1:0] m = '0;
        for (int i = 0; i < ND; i++) if (c[i]) m[i*DW +: DW] = {DW{1'b1}};
        return m;
    endfunction

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_mask_q.delete();
        rs_addr_q.delete(); rs_data_q.delete(); rs_cor_q.delete(); rs_unc_q.delete();
        cor_pulses = 0; unc_pulses = 0; cancel_seen = 0; req_at_cancel = 0;
    endtask

    task automatic clear_tables();
        for (int r = 0; r < DEPTH; r++) begin
            tab_cor[r] = '0; tab_unc[r] = '0; tab_data[r] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i = 1'b1; en_i = 1'b0; sram_gnt_i = 1'b0; fn_wr_i = 1'b0;
        sram_err_cor_i = '0; sram_err_unc_i = '0; sram_rdata_i = '0;
        pending = 0;
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        clear_logs();
    endtask

    // One clock of SRAM-side behaviour; inputs change mid-cycle, outputs observed after them
    task automatic tick();
        logic [W-1:0]  d;
        logic [ND-1:0] c, u;
        int r;
        @(negedge clk);
        rst_i = 1'b0; fn_wr_i = 1'b0; fn_wr_addr_i = '0;
        sram_rdata_i = '0; sram_err_cor_i = '0; sram_err_unc_i = '0;
        if (pending) begin
            if (rand_mode) begin
                d = {$urandom(), $urandom(), $urandom(), $urandom()};
                r = $urandom_range(9);
                c = (r < 4) ? ND'($urandom_range(3, 1)) : '0;
                u = (r == 4) ? ND'(1 << $urandom_range(ND - 1)) : '0;
            end else begin
                d = tab_data[pend_addr[1:0]]; c = tab_cor[pend_addr[1:0]]; u = tab_unc[pend_addr[1:0]];
            end
            sram_rdata_i = d; sram_err_cor_i = c; sram_err_unc_i = u;
            rs_addr_q.push_back(int'(pend_addr)); rs_data_q.push_back(d);
            rs_cor_q.push_back(c); rs_unc_q.push_back(u);
            if (rst_in_resp) begin
                rst_i = 1'b1; rst_in_resp = 0;
            end
        end
        sram_gnt_i = ($urandom_range(99) < gnt_pct);
        #1;
        if (cancel_wb && sram_we_o && sram_req_o) begin
            fn_wr_i = 1'b1; fn_wr_addr_i = sram_addr_o; sram_gnt_i = 1'b0;
            cancel_wb = 0; cancel_seen = 1;
            #1;
            req_at_cancel = sram_req_o;
        end
        #1;
        pending = 0;
        if (!rst_i && sram_req_o && sram_gnt_i && !sram_we_o) begin
            pending = 1; pend_addr = sram_addr_o;
            rd_addr_q.push_back(int'(sram_addr_o)); rd_cyc_q.push_back(cyc);
        end
        if (sram_req_o && sram_gnt_i && sram_we_o) begin
            wr_addr_q.push_back(int'(sram_addr_o)); wr_data_q.push_back(sram_wdata_o); wr_mask_q.push_back(sram_wmask_o);
        end
        if (cor_evt_o) cor_pulses++;
        if (unc_evt_o) unc_pulses++;
        cyc++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (sram_req_o !== 1'b0 || sram_we_o !== 1'b0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL reset_ctrl: req=%b we=%b busy=%b, required 0/0/0", sram_req_o, sram_we_o, busy_o); end
        checks++; if (sram_addr_o !== '0 || sram_wdata_o !== '0 || sram_wmask_o !== '0) begin errors++;
            $display("FAIL reset_sram_bus: addr=%0h wdata=%0h wmask=%0h, required 0", sram_addr_o, sram_wdata_o, sram_wmask_o); end
        checks++; if (cor_evt_o !== 1'b0 || unc_evt_o !== 1'b0) begin errors++;
            $display("FAIL reset_evt: cor=%b unc=%b, required 0", cor_evt_o, unc_evt_o); end
        checks++; if (cor_cnt_o !== 16'd0 || unc_cnt_o !== 16'd0 || unc_addr_o !== '0) begin errors++;
            $display("FAIL reset_log: cor_cnt=%0d unc_cnt=%0d unc_addr=%0d, required 0", cor_cnt_o, unc_cnt_o, unc_addr_o); end
    endtask

    task automatic test_sweep();
        int bad = 0;
        do_reset(); clear_tables(); rand_mode = 0; gnt_pct = 100;
        period_i = 16'd0; en_i = 1'b1;
        for (int t = 0; t < 40 && rd_addr_q.size() < 5; t++) tick();
        checks++; if (rd_addr_q.size() < 5) begin errors++;
            $display("FAIL sweep_reads: got %0d reads, required 5", rd_addr_q.size()); end
        else begin
            for (int k = 0; k < 5; k++) if (rd_addr_q[k] != k % DEPTH) bad++;
            checks++; if (bad != 0) begin errors++;
                $display("FAIL sweep_order: %0d of 5 read addresses wrong (first %0d), required 0,1,2,3,0", bad, rd_addr_q[0]); end
            bad = 0;
            for (int k = 0; k < 4; k++) if (rd_cyc_q[k+1] - rd_cyc_q[k] != 2) bad++;
            checks++; if (bad != 0) begin errors++;
                $display("FAIL sweep_slot: %0d read gaps differ (gap0=%0d), required 2 cycles", bad, rd_cyc_q[1] - rd_cyc_q[0]); end
        end
        checks++; if (wr_addr_q.size() != 0 || cor_pulses != 0 || unc_pulses != 0) begin errors++;
            $display("FAIL sweep_quiet: writes=%0d cor=%0d unc=%0d, required 0", wr_addr_q.size(), cor_pulses, unc_pulses); end
    endtask

    task automatic test_cor_wb();
        logic [W-1:0] exp_mask;
        do_reset(); clear_tables(); rand_mode = 0; gnt_pct = 100;
        tab_cor[2] = 2'b01;
        tab_data[2] = {64'h1234_5678_9ABC_DEF0, 64'h0000_0000_0000_00A5};
        exp_mask = {{DW{1'b0}}, {DW{1'b1}}};
        period_i = 16'd0; en_i = 1'b1;
        for (int t = 0; t < 40 && wr_addr_q.size() < 1; t++) tick();
        en_i = 1'b0;
        repeat (3) tick();
        checks++; if (wr_addr_q.size() != 1) begin errors++;
            $display("FAIL cor_wr_count: %0d writes, required 1", wr_addr_q.size()); end
        else begin
            checks++; if (wr_addr_q[0] != 2 || wr_data_q[0] !== tab_data[2]) begin errors++;
                $display("FAIL cor_wr_dat: addr=%0d data=%h, required addr 2 data %h", wr_addr_q[0], wr_data_q[0], tab_data[2]); end
            checks++; if (wr_mask_q[0] !== exp_mask) begin errors++;
                $display("FAIL cor_wr_mask: %h, required %h", wr_mask_q[0], exp_mask); end
        end
        checks++; if (cor_pulses != 1 || unc_pulses != 0) begin errors++;
            $display("FAIL cor_evt: cor pulses %0d unc pulses %0d, required 1/0", cor_pulses, unc_pulses); end
        checks++; if (cor_cnt_o !== (LOG_EN ? 16'd1 : 16'd0)) begin errors++;
            $display("FAIL cor_cnt: %0d, required %0d", cor_cnt_o, LOG_EN ? 1 : 0); end
    endtask

    task automatic test_unc();
        do_reset(); clear_tables(); rand_mode = 0; gnt_pct = 100;
        tab_unc[1] = 2'b10; tab_cor[1] = 2'b11; tab_data[1] = {2{64'hDEAD_BEEF_0000_1111}};
        period_i = 16'd0; en_i = 1'b1;
        for (int t = 0; t < 40 && rd_addr_q.size() < 3; t++) tick();
        en_i = 1'b0;
        repeat (4) tick();
        checks++; if (unc_pulses != 1 || cor_pulses != 0) begin errors++;
            $display("FAIL unc_evt: unc pulses %0d cor pulses %0d, required 1/0", unc_pulses, cor_pulses); end
        checks++; if (wr_addr_q.size() != 0) begin errors++;
            $display("FAIL unc_no_wb: %0d writes, required 0", wr_addr_q.size()); end
        checks++; if (unc_cnt_o !== (LOG_EN ? 16'd1 : 16'd0) || unc_addr_o !== (LOG_EN ? AW'(1) : AW'(0))) begin errors++;
            $display("FAIL unc_log: cnt=%0d addr=%0d, required %0d/%0d", unc_cnt_o, unc_addr_o, LOG_EN ? 1 : 0, LOG_EN ? 1 : 0); end
    endtask

    task automatic test_fn_cancel();
        do_reset(); clear_tables(); rand_mode = 0; gnt_pct = 100;
        tab_cor[3] = 2'b01; tab_data[3] = {64'h0, 64'h5A5A};
        cancel_wb = 1;
        period_i = 16'd0; en_i = 1'b1;
        for (int t = 0; t < 60 && rd_addr_q.size() < 5; t++) tick();
        en_i = 1'b0; cancel_wb = 0;
        repeat (3) tick();
        checks++; if (!cancel_seen || req_at_cancel !== 1'b0) begin errors++;
            $display("FAIL cancel_req: seen=%0d req during snoop=%b, required 1/0", cancel_seen, req_at_cancel); end
        checks++; if (wr_addr_q.size() != 0) begin errors++;
            $display("FAIL cancel_no_wb: %0d writes, required 0", wr_addr_q.size()); end
        checks++; if (rd_addr_q.size() < 5 || rd_addr_q[4] != 0) begin errors++;
            $display("FAIL cancel_ptr: reads=%0d next row=%0d, required row 0", rd_addr_q.size(),
                     rd_addr_q.size() >= 5 ? rd_addr_q[4] : -1); end
        checks++; if (cor_pulses != 1) begin errors++;
            $display("FAIL cancel_evt: cor pulses %0d, required 1", cor_pulses); end
    endtask

    task automatic test_reset_in_resp();
        int bad = 0;
        do_reset(); clear_tables(); rand_mode = 0; gnt_pct = 100;
        tab_cor[0] = 2'b11; tab_data[0] = {2{64'hCAFE}};
        rst_in_resp = 1; period_i = 16'd0; en_i = 1'b1;
        for (int t = 0; t < 20 && rst_in_resp; t++) tick();
        checks++; if (rst_in_resp) begin errors++; rst_in_resp = 0;
            $display("FAIL rstresp_reach: never reached RESP, required one read"); end
        en_i = 1'b0; tab_cor[0] = '0; clear_logs();
        repeat (4) tick();
        checks++; if (wr_addr_q.size() != 0 || cor_pulses != 0 || busy_o !== 1'b0) begin errors++;
            $display("FAIL rstresp_discard: writes=%0d cor pulses=%0d busy=%b, required 0/0/0", wr_addr_q.size(), cor_pulses, busy_o); end
        checks++; if (cor_cnt_o !== 16'd0 || unc_cnt_o !== 16'd0) begin errors++;
            $display("FAIL rstresp_cnt: cor=%0d unc=%0d, required 0", cor_cnt_o, unc_cnt_o); end
        period_i = 16'd5; en_i = 1'b1;
        for (int t = 0; t < 80 && rd_addr_q.size() < 3; t++) tick();
        en_i = 1'b0;
        checks++; if (rd_addr_q.size() < 3 || rd_addr_q[0] != 0 || rd_addr_q[1] != 1) begin errors++;
            $display("FAIL rstresp_ptr: reads=%0d first=%0d, required rows 0,1", rd_addr_q.size(),
                     rd_addr_q.size() > 0 ? rd_addr_q[0] : -1); end
        else begin
            for (int k = 0; k < 2; k++) if (rd_cyc_q[k+1] - rd_cyc_q[k] != 2 + 5) bad++;
            checks++; if (bad != 0) begin errors++;
                $display("FAIL period_gap: read gap %0d, required 7 (2 + 5 wait)", rd_cyc_q[1] - rd_cyc_q[0]); end
        end
    endtask

    task automatic test_random();
        int quiet = 0, bad_rd = 0, bad_wr = 0, n_cor = 0, n_unc = 0, last_unc = 0;
        int ex_addr[$];
        logic [W-1:0] ex_data[$], ex_mask[$];
        do_reset(); clear_tables(); rand_mode = 1; gnt_pct = 60;
        period_i = 16'($urandom_range(3)); en_i = 1'b1;
        for (int t = 0; t < 2000 && rd_addr_q.size() < 24; t++) tick();
        en_i = 1'b0;
        for (int t = 0; t < 300 && quiet < 8; t++) begin
            tick();
            quiet = (busy_o || pending) ? 0 : quiet + 1;
        end
        // Row-level model: every row visited in order; unc dominates cor; cor rows rewritten once
        foreach (rd_addr_q[k]) if (rd_addr_q[k] != k % DEPTH) bad_rd++;
        foreach (rs_addr_q[k]) begin
            if (rs_unc_q[k] != '0) begin
                n_unc++; last_unc = rs_addr_q[k];
            end else if (rs_cor_q[k] != '0) begin
                n_cor++;
                ex_addr.push_back(rs_addr_q[k]); ex_data.push_back(rs_data_q[k]); ex_mask.push_back(mask_of(rs_cor_q[k]));
            end
        end
        checks++; if (bad_rd != 0 || rs_addr_q.size() != rd_addr_q.size() || rd_addr_q.size() < 24) begin errors++;
            $display("FAIL rand_reads: %0d bad addrs, %0d reads, %0d responses, required in-order and equal", bad_rd, rd_addr_q.size(), rs_addr_q.size()); end
        if (wr_addr_q.size() != ex_addr.size()) bad_wr = 1;
        else foreach (ex_addr[k])
            if (wr_addr_q[k] != ex_addr[k] || wr_data_q[k] !== ex_data[k] || wr_mask_q[k] !== ex_mask[k]) bad_wr++;
        checks++; if (bad_wr != 0) begin errors++;
            $display("FAIL rand_writes: %0d writes (%0d bad), required %0d", wr_addr_q.size(), bad_wr, ex_addr.size()); end
        checks++; if (cor_pulses != n_cor || unc_pulses != n_unc) begin errors++;
            $display("FAIL rand_evts: cor=%0d unc=%0d, required %0d/%0d", cor_pulses, unc_pulses, n_cor, n_unc); end
        checks++; if (cor_cnt_o !== (LOG_EN ? 16'(n_cor) : 16'd0) || unc_cnt_o !== (LOG_EN ? 16'(n_unc) : 16'd0)
                      || unc_addr_o !== (LOG_EN ? AW'(last_unc) : AW'(0))) begin errors++;
            $display("FAIL rand_log: cor_cnt=%0d unc_cnt=%0d unc_addr=%0d, required %0d/%0d/%0d", cor_cnt_o, unc_cnt_o,
                     unc_addr_o, LOG_EN ? n_cor : 0, LOG_EN ? n_unc : 0, LOG_EN ? last_unc : 0); end
        rand_mode = 0;
    endtask

    initial begin
        clear_tables();
        test_reset();
        test_sweep();
        test_cor_wb();
        test_unc();
        test_fn_cancel();
        test_reset_in_resp();
        test_random();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
